// File: rtl/pipelined_lookahead_subtractor_pkg.sv
// Shared constants and the per-stage payload carried down the subtractor pipeline.
package pipelined_lookahead_subtractor_pkg;

    localparam int WIDTH_DEFAULT   = 64;
    localparam int STAGES_DEFAULT  = 4;
    localparam int SLICE_W         = WIDTH_DEFAULT / STAGES_DEFAULT;
    localparam int CELLS_PER_SLICE = SLICE_W / 2;

    // Operands ride along whole; each stage only reads its own slice, so the
    // already-consumed low operand bits are dead and fall away in synthesis.
    typedef struct packed {
        logic [WIDTH_DEFAULT-1:0] a;
        logic [WIDTH_DEFAULT-1:0] b;
        logic [WIDTH_DEFAULT-1:0] diff;
        logic                     borrow;
        logic                     zero;
        logic                     a_sgn;
        logic                     b_sgn;
    } stage_t;

endpackage

// File: rtl/pipelined_lookahead_subtractor_cls.sv
// 2-bit borrow-lookahead cell: DIFF = A - B - BIN over two bits, BOUT resolved in one level.
module cls_subtractor
    import pipelined_lookahead_subtractor_pkg::*;
(
    input  logic [1:0] A,
    input  logic [1:0] B,
    input  logic       BIN,
    output logic [1:0] DIFF,
    output logic       BOUT
);

    logic [1:0] w_g;
    logic [1:0] w_p;
    logic       w_b1;

    // generate: a=0,b=1 always borrows; propagate: a==b passes the incoming borrow
    assign w_g  = ~A & B;
    assign w_p  = ~(A ^ B);
    assign w_b1 = w_g[0] | (w_p[0] & BIN);
    assign BOUT = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & BIN);
    assign DIFF = {A[1] ^ B[1] ^ w_b1, A[0] ^ B[0] ^ BIN};

endmodule

// File: rtl/pipelined_lookahead_subtractor.sv
// Four-stage valid/ready pipelined A - B; each stage resolves one slice of DIFF
// from its operand slice and the registered borrow of the previous stage.
module pipelined_lookahead_subtractor
    import pipelined_lookahead_subtractor_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEFAULT,
    parameter int STAGES = STAGES_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] DIFF,
    output logic             BORROW,
    output logic             OVERFLOW,
    output logic             ZERO
);

    localparam int SW = WIDTH / STAGES;
    localparam int NC = SW / 2;

    logic [STAGES-1:0] w_vld;
    logic [STAGES-1:0] w_load;
    stage_t            w_last;
    logic              w_last_v;
    logic              w_unused;

    // A stage loads if it is empty or its successor is moving; bubbles collapse.
    always_comb begin
        logic w_l;
        w_load           = '0;
        w_l              = !w_vld[STAGES-1] || OUT_READY;
        w_load[STAGES-1] = w_l;
        for (int k = STAGES - 2; k >= 0; k--) begin
            w_l       = !w_vld[k] || w_l;
            w_load[k] = w_l;
        end
    end

    assign IN_READY = w_load[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        stage_t        w_in;
        stage_t        w_out;
        stage_t        r_q;
        logic          w_up_v;
        logic          r_v;
        logic [NC:0]   w_bc;
        logic [SW-1:0] w_d;

        if (k == 0) begin : g_head
            always_comb begin
                w_in       = '0;
                w_in.a     = A;
                w_in.b     = B;
                w_in.zero  = 1'b1;
                w_in.a_sgn = A[WIDTH-1];
                w_in.b_sgn = B[WIDTH-1];
            end
            assign w_up_v = IN_VALID;
        end else begin : g_body
            assign w_in   = g_stg[k-1].r_q;
            assign w_up_v = g_stg[k-1].r_v;
        end

        assign w_bc[0] = w_in.borrow;
        for (genvar c = 0; c < NC; c++) begin : g_cell
            cls_subtractor u_cell (
                .A    (w_in.a[k*SW + 2*c +: 2]),
                .B    (w_in.b[k*SW + 2*c +: 2]),
                .BIN  (w_bc[c]),
                .DIFF (w_d[2*c +: 2]),
                .BOUT (w_bc[c+1])
            );
        end

        always_comb begin
            w_out                   = w_in;
            w_out.diff[k*SW +: SW]  = w_d;
            w_out.borrow            = w_bc[NC];
            w_out.zero              = w_in.zero && (w_d == '0);
        end

        // Data only moves with a real operation so stalled or idle outputs hold.
        always_ff @(posedge CLK) begin
            if (!RST_N) begin
                r_v <= 1'b0;
                r_q <= '0;
            end else begin
                if (w_load[k]) r_v <= w_up_v;
                if (w_load[k] && w_up_v) r_q <= w_out;
            end
        end

        assign w_vld[k] = r_v;
    end

    assign w_last   = g_stg[STAGES-1].r_q;
    assign w_last_v = g_stg[STAGES-1].r_v;
    assign w_unused = ^{w_last.a, w_last.b};

    assign OUT_VALID = w_last_v;
    assign DIFF      = w_last.diff;
    assign BORROW    = w_last.borrow;
    assign ZERO      = w_last.zero;
    assign OVERFLOW  = (w_last.a_sgn ^ w_last.b_sgn) & (w_last.diff[WIDTH-1] ^ w_last.a_sgn);

endmodule

// File: tb/tb_pipelined_lookahead_subtractor.sv
// Scoreboard bench for the pipelined subtractor: directed corners, streaming,
// output backpressure and a mid-stream reset.
module tb_pipelined_lookahead_subtractor;
    import pipelined_lookahead_subtractor_pkg::*;

    localparam int W = 64;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         borrow;
        logic         ovf;
        logic         zero;
    } exp_t;

    logic         CLK = 1'b0;
    logic         RST_N, IN_VALID, IN_READY, OUT_VALID, OUT_READY;
    logic         BORROW, OVERFLOW, ZERO;
    logic [W-1:0] A, B, DIFF;

    exp_t sb[$];
    exp_t mon_got, mon_exp;
    int   n_chk = 0, n_fail = 0, n_acc = 0, n_timeout = 0;
    bit   mon_en = 1'b0;

    always #5 CLK = ~CLK;

    pipelined_lookahead_subtractor #(.WIDTH(W), .STAGES(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .A(A), .B(B), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .DIFF(DIFF), .BORROW(BORROW), .OVERFLOW(OVERFLOW), .ZERO(ZERO)
    );

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.diff   = a - b;
        e.borrow = (a < b);
        e.ovf    = (a[W-1] != b[W-1]) && (e.diff[W-1] != a[W-1]);
        e.zero   = (e.diff == '0);
        return e;
    endfunction

    // Scoreboard pop on every output transfer.
    always @(negedge CLK) begin
        if (mon_en && OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
            mon_got = {DIFF, BORROW, OVERFLOW, ZERO};
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_unexpected: got diff=%h b=%b o=%b z=%b, required no output",
                         DIFF, BORROW, OVERFLOW, ZERO);
            end else begin
                mon_exp = sb.pop_front();
                if (mon_got !== mon_exp) begin
                    n_fail++;
                    $display("FAIL scoreboard_result: got diff=%h b=%b o=%b z=%b, required diff=%h b=%b o=%b z=%b",
                             mon_got.diff, mon_got.borrow, mon_got.ovf, mon_got.zero,
                             mon_exp.diff, mon_exp.borrow, mon_exp.ovf, mon_exp.zero);
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        bit rdy;
        int g = 0;
        A = a; B = b; IN_VALID = 1'b1;
        do begin
            @(negedge CLK); rdy = IN_READY;
            @(posedge CLK); #1; g++;
        end while (!rdy && g < 100);
        if (rdy) begin
            sb.push_back(model(a, b));
            n_acc++;
        end else n_timeout++;
        IN_VALID = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 1;
        while (OUT_VALID !== 1'b1 && cyc < 50) begin
            @(posedge CLK); #1; cyc++;
        end
    endtask

    task automatic drain();
        int i = 0;
        while (sb.size() != 0 && i < 200) begin
            @(posedge CLK); #1; i++;
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1; A = '0; B = '0;
        repeat (2) @(posedge CLK);
        #1; RST_N = 1'b1; mon_en = 1'b1;
        n_chk++;
        if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", OUT_VALID); end
        n_chk++;
        if (DIFF !== '0) begin n_fail++; $display("FAIL reset_diff: got %h, required 0", DIFF); end
        n_chk++;
        if ({BORROW, OVERFLOW, ZERO} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got b/o/z=%b%b%b, required 000", BORROW, OVERFLOW, ZERO);
        end
        n_chk++;
        if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 1", IN_READY); end
    endtask

    task automatic test_basic();
        int lat;
        send(64'h10, 64'h03); wait_out(lat);
        n_chk++;
        if (lat !== 4) begin n_fail++; $display("FAIL basic_latency: got %0d cycles, required 4", lat); end
        n_chk++;
        if (DIFF !== 64'h0D || {BORROW, OVERFLOW, ZERO} !== 3'b000) begin
            n_fail++; $display("FAIL basic_result: got diff=%h b/o/z=%b%b%b, required 000000000000000d 000",
                               DIFF, BORROW, OVERFLOW, ZERO);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_wrap();
        int lat;
        send(64'h0, 64'h1); wait_out(lat);
        n_chk++;
        if (DIFF !== 64'hFFFF_FFFF_FFFF_FFFF || {BORROW, OVERFLOW, ZERO} !== 3'b100) begin
            n_fail++; $display("FAIL wrap_result: got diff=%h b/o/z=%b%b%b, required ffffffffffffffff 100",
                               DIFF, BORROW, OVERFLOW, ZERO);
        end
        @(posedge CLK); #1;
        send(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0); wait_out(lat);
        n_chk++;
        if (DIFF !== '0 || {BORROW, OVERFLOW, ZERO} !== 3'b001) begin
            n_fail++; $display("FAIL equal_result: got diff=%h b/o/z=%b%b%b, required 0 001",
                               DIFF, BORROW, OVERFLOW, ZERO);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_overflow();
        int lat;
        send(64'h8000_0000_0000_0000, 64'h1); wait_out(lat);
        n_chk++;
        if (DIFF !== 64'h7FFF_FFFF_FFFF_FFFF || {BORROW, OVERFLOW, ZERO} !== 3'b010) begin
            n_fail++; $display("FAIL overflow_result: got diff=%h b/o/z=%b%b%b, required 7fffffffffffffff 010",
                               DIFF, BORROW, OVERFLOW, ZERO);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_cross_slice();
        int lat;
        send(64'h0000_0001_0000_0000, 64'h1); wait_out(lat);
        n_chk++;
        if (DIFF !== 64'h0000_0000_FFFF_FFFF || {BORROW, OVERFLOW, ZERO} !== 3'b000) begin
            n_fail++; $display("FAIL cross_slice_result: got diff=%h b/o/z=%b%b%b, required 00000000ffffffff 000",
                               DIFF, BORROW, OVERFLOW, ZERO);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_back_to_back();
        time t0;
        int  cycles;
        t0 = $time;
        for (int i = 0; i < 12; i++) send({$urandom, $urandom}, {$urandom, $urandom});
        cycles = int'(($time - t0) / 10);
        n_chk++;
        if (cycles !== 12) begin n_fail++; $display("FAIL b2b_throughput: got %0d cycles for 12 ops, required 12", cycles); end
        drain();
        n_chk++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL b2b_drain: got %0d pending, required 0", sb.size()); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] ra [8];
        logic [W-1:0] rb [8];
        int   acc0, unstable, nvalid;
        exp_t held;
        bit   have;
        for (int i = 0; i < 8; i++) begin
            ra[i] = {$urandom, $urandom};
            rb[i] = {$urandom, $urandom};
        end
        acc0 = n_acc; unstable = 0; nvalid = 0; have = 1'b0; held = '0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(ra[i], rb[i]);
            end
            begin
                @(posedge CLK); #1; OUT_READY = 1'b0;
                repeat (8) begin
                    @(negedge CLK);
                    if (OUT_VALID === 1'b1) begin
                        nvalid++;
                        if (have && {DIFF, BORROW, OVERFLOW, ZERO} !== held) unstable++;
                        held = {DIFF, BORROW, OVERFLOW, ZERO};
                        have = 1'b1;
                    end
                    @(posedge CLK); #1;
                end
                n_chk++;
                if (n_acc - acc0 !== 4) begin
                    n_fail++; $display("FAIL bp_accepted: got %0d accepted while stalled, required 4", n_acc - acc0);
                end
                n_chk++;
                if (IN_READY !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b when full, required 0", IN_READY); end
                n_chk++;
                if (nvalid !== 5 || unstable !== 0) begin
                    n_fail++; $display("FAIL bp_hold: got %0d valid samples, %0d changes, required 5 and 0", nvalid, unstable);
                end
                OUT_READY = 1'b1;
            end
        join
        drain();
        n_chk++;
        if (sb.size() != 0 || n_acc - acc0 !== 8) begin
            n_fail++; $display("FAIL bp_drain: got %0d pending %0d accepted, required 0 and 8", sb.size(), n_acc - acc0);
        end
    endtask

    task automatic test_reset_midstream();
        int lat, seen;
        for (int i = 0; i < 3; i++) send({$urandom, $urandom}, {$urandom, $urandom});
        RST_N = 1'b0;
        @(posedge CLK); #1;
        RST_N = 1'b1;
        sb.delete();
        n_chk++;
        if (OUT_VALID !== 1'b0 || DIFF !== '0 || {BORROW, OVERFLOW, ZERO} !== 3'b000) begin
            n_fail++; $display("FAIL midreset_outputs: got v=%b diff=%h b/o/z=%b%b%b, required all 0",
                               OUT_VALID, DIFF, BORROW, OVERFLOW, ZERO);
        end
        seen = 0;
        repeat (8) begin
            @(negedge CLK);
            if (OUT_VALID !== 1'b0) seen++;
        end
        @(posedge CLK); #1;
        n_chk++;
        if (seen !== 0) begin n_fail++; $display("FAIL midreset_stale: got %0d stale valid cycles, required 0", seen); end
        send(64'hDEAD_BEEF_0000_0000, 64'h0000_0000_0000_0001); wait_out(lat);
        n_chk++;
        if (lat !== 4 || DIFF !== 64'hDEAD_BEEE_FFFF_FFFF) begin
            n_fail++; $display("FAIL midreset_next: got lat=%0d diff=%h, required 4 deadbeeeffffffff", lat, DIFF);
        end
        @(posedge CLK); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_overflow();
        test_cross_slice();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        drain();
        n_chk++;
        if (n_timeout !== 0) begin n_fail++; $display("FAIL send_timeout: got %0d timeouts, required 0", n_timeout); end
        n_chk++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL final_pending: got %0d results missing, required 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
